// File: rtl/fifo_dot_mac_pkg.sv
// fifo_dot_mac_pkg
//   Shared constants, state encoding and sizing helper for the FIFO-fed
//   dot-product MAC (fifo_dot_mac and its mac_pe datapath).
package fifo_dot_mac_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_VEC_LEN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } t_mac_state;

  // Width of a counter that must represent 0..vec_len inclusive.
  function automatic int COUNT_W(input int vec_len);
    return $clog2(vec_len + 1);
  endfunction

endpackage

// File: rtl/fifo_dot_mac_pe.sv
// mac_pe
//   Signed multiply, sign-extend and accumulate register for fifo_dot_mac.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     i_load     clear the accumulator (wins over i_en)
//     i_first    start a new sum: next value is the product alone
//     i_en       commit o_sum into the accumulator
//     i_a, i_b   signed DATA_W operands
//     o_sum      combinational next sum (product, or acc + product), ACC_W
module mac_pe
  import fifo_dot_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_first,
  input  logic                    i_en,
  input  logic [DATA_W-1:0]       i_a,
  input  logic [DATA_W-1:0]       i_b,
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_ext;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = $signed(i_a) * $signed(i_b);
  // Size cast of a signed operand sign-extends; also valid when ACC_W == 2*DATA_W.
  assign w_ext  = ACC_W'(w_prod);
  // Plain ACC_W-bit add: wraps modulo 2^ACC_W by construction.
  assign o_sum  = i_first ? w_ext : (r_acc + w_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/fifo_dot_mac.sv
// fifo_dot_mac
//   Consumes paired signed elements from two FIFOs, forms their dot product
//   over VEC_LEN pairs, and presents it on a valid/ready result port. While
//   a result is pending, input acceptance is stalled.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     clr                  synchronous abort (drops partial vector and result)
//     a_valid/a_data       A element stream
//     b_valid/b_data       B element stream
//     in_ready             pop enable for both FIFOs (state-only)
//     res_valid/res_data   result handshake, res_ready from consumer
//     busy                 high while accumulating or holding a result
//     count                pairs accepted in the current vector
module fifo_dot_mac
  import fifo_dot_mac_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int VEC_LEN = DEF_VEC_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         a_valid,
  input  logic [DATA_W-1:0]            a_data,
  input  logic                         b_valid,
  input  logic [DATA_W-1:0]            b_data,
  output logic                         in_ready,
  output logic                         res_valid,
  output logic [ACC_W-1:0]             res_data,
  input  logic                         res_ready,
  output logic                         busy,
  output logic [COUNT_W(VEC_LEN)-1:0]  count
);

  localparam int CNT_W = COUNT_W(VEC_LEN);

  t_mac_state              r_state, w_state_next;
  logic [CNT_W-1:0]        r_count, w_count_next;
  logic                    r_res_valid, w_res_valid_next;
  logic [ACC_W-1:0]        r_res_data, w_res_data_next;
  logic                    w_accept, w_last, w_first, w_pe_load, w_pe_en;
  logic signed [ACC_W-1:0] w_sum;

  assign in_ready  = (r_state != HOLD);
  assign busy      = (r_state != IDLE);
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign count     = r_count;

  assign w_accept = a_valid & b_valid & in_ready;
  // Count is 0 in IDLE, so with VEC_LEN==1 the first accept is also the last.
  assign w_last   = (r_count == CNT_W'(VEC_LEN - 1));
  assign w_first  = (r_state == IDLE);
  assign w_pe_en  = w_accept & ~clr;

  mac_pe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_pe (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_pe_load),
    .i_first (w_first),
    .i_en    (w_pe_en),
    .i_a     (a_data),
    .i_b     (b_data),
    .o_sum   (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_res_valid <= w_res_valid_next;
      r_res_data  <= w_res_data_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_res_valid_next = r_res_valid;
    w_res_data_next  = r_res_data;
    w_pe_load        = 1'b0;

    if (clr) begin
      // Abort: any same-cycle accept or handshake is dropped; res_data kept.
      w_state_next     = IDLE;
      w_count_next     = '0;
      w_res_valid_next = 1'b0;
      w_pe_load        = 1'b1;
    end else begin
      unique case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            w_count_next = r_count + CNT_W'(1);
            if (w_last) begin
              w_res_valid_next = 1'b1;
              w_res_data_next  = w_sum;
              w_state_next     = HOLD;
            end else begin
              w_state_next = ACCUM;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            w_res_valid_next = 1'b0;
            w_count_next     = '0;
            w_pe_load        = 1'b1;
            w_state_next     = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_dot_mac.sv
module tb_fifo_dot_mac;
  import fifo_dot_mac_pkg::*;

  localparam int VL = 8;
  localparam int CW = COUNT_W(VL);

  logic        clk = 1'b0;
  logic        rst, clr, a_valid, b_valid, res_ready;
  logic [7:0]  a_data, b_data;

  logic        in_ready24, res_valid24, busy24;
  logic [23:0] res_data24;
  logic [CW-1:0] count24;
  logic        in_ready16, res_valid16, busy16;
  logic [15:0] res_data16;
  logic [CW-1:0] count16;

  always #5 clk = ~clk;

  fifo_dot_mac #(.DATA_W(8), .ACC_W(24), .VEC_LEN(VL)) dut24 (
    .clk(clk), .rst(rst), .clr(clr),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .in_ready(in_ready24), .res_valid(res_valid24), .res_data(res_data24),
    .res_ready(res_ready), .busy(busy24), .count(count24)
  );

  fifo_dot_mac #(.DATA_W(8), .ACC_W(16), .VEC_LEN(VL)) dut16 (
    .clk(clk), .rst(rst), .clr(clr),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .in_ready(in_ready16), .res_valid(res_valid16), .res_data(res_data16),
    .res_ready(res_ready), .busy(busy16), .count(count16)
  );

  int checks = 0;
  int errors = 0;

  // Reference: number of pairs gathered, exact integer sum, and whether a
  // finished result is waiting for the consumer.
  int          m_n;
  bit          m_hold;
  longint      m_sum;
  logic [23:0] m_res24;
  logic [15:0] m_res16;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_hold = 0; m_sum = 0; m_res24 = '0; m_res16 = '0;
  endtask

  // Apply the effect of one clock edge with the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (clr) begin
      m_n = 0; m_hold = 0; m_sum = 0;
    end else if (m_hold) begin
      if (res_ready) begin
        m_n = 0; m_hold = 0; m_sum = 0;
      end
    end else if (a_valid && b_valid) begin
      m_sum = m_sum + longint'($signed(a_data)) * longint'($signed(b_data));
      m_n++;
      if (m_n == VL) begin
        m_hold  = 1;
        m_res24 = m_sum[23:0];
        m_res16 = m_sum[15:0];
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready24",  {63'd0, in_ready24},  {63'd0, !m_hold});
    chk("res_valid24", {63'd0, res_valid24}, {63'd0, m_hold});
    chk("res_data24",  {40'd0, res_data24},  {40'd0, m_res24});
    chk("busy24",      {63'd0, busy24},      {63'd0, (m_hold || m_n > 0)});
    chk("count24",     64'(count24),         64'(m_n));
    chk("in_ready16",  {63'd0, in_ready16},  {63'd0, !m_hold});
    chk("res_valid16", {63'd0, res_valid16}, {63'd0, m_hold});
    chk("res_data16",  {48'd0, res_data16},  {48'd0, m_res16});
    chk("busy16",      {63'd0, busy16},      {63'd0, (m_hold || m_n > 0)});
    chk("count16",     64'(count16),         64'(m_n));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit av, input logic [7:0] a, input bit bv,
                       input logic [7:0] b, input bit rr, input bit c);
    a_valid = av; a_data = a; b_valid = bv; b_data = b; res_ready = rr; clr = c;
  endtask

  task automatic run_vec(input int a, input int b, input bit rr);
    logic [7:0] av8, bv8;
    av8 = a[7:0];
    bv8 = b[7:0];
    for (int i = 0; i < VL; i++) begin
      drive(1, av8, 1, bv8, rr, 0);
      step();
    end
  endtask

  task automatic handshake();
    drive(0, 8'd0, 0, 8'd0, 1, 0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'd0, 0, 8'd0, 0, 0);
    model_reset();
    #2;
    check_all();
    step();
    rst = 1'b0;
    step();
    $display("reset: in_ready=%0d res_valid=%0d count=%0d", in_ready24, res_valid24, count24);

    // 1..8 dot 1 = 36, result visible the cycle after the 8th accept
    for (int i = 1; i <= VL; i++) begin
      drive(1, 8'(i), 1, 8'd1, 1, 0);
      step();
    end
    chk("lit_valid_after_8", {63'd0, res_valid24}, 64'd1);
    chk("lit_dot36", {40'd0, res_data24}, 64'd36);
    $display("vec 1..8 x 1: res_data=%0d", $signed(res_data24));
    handshake();
    chk("lit_count_after_hs", 64'(count24), 64'd0);

    // -128*127 x8 = -130048
    run_vec(-128, 127, 0);
    chk("lit_neg24", {40'd0, res_data24}, 64'h00FE0400);
    chk("lit_neg16", {48'd0, res_data16}, 64'h0400);
    $display("vec -128 x 127: res24=%0h res16=%0h", res_data24, res_data16);

    // Backpressure: result held, no pops
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'($urandom), 1, 8'($urandom), 0, 0);
      step();
      chk("lit_bp_in_ready", {63'd0, in_ready24}, 64'd0);
      chk("lit_bp_count", 64'(count24), 64'(VL));
    end
    drive(1, 8'd5, 1, 8'd5, 1, 0);
    step();
    chk("lit_bp_release_idle", {63'd0, busy24}, 64'd0);
    drive(1, 8'd1, 1, 8'd1, 0, 0);
    step();
    chk("lit_new_vec_count", 64'(count24), 64'd1);
    for (int i = 1; i < VL; i++) begin
      drive(1, 8'd1, 1, 8'd1, 0, 0);
      step();
    end
    handshake();
    $display("backpressure: held 5 cycles, new vector started after release");

    // -128*-128 x8 = 131072: fits 24 bits, wraps to 0 in 16 bits
    run_vec(-128, -128, 0);
    chk("lit_wrap16", {48'd0, res_data16}, 64'h0);
    chk("lit_nowrap24", {40'd0, res_data24}, 64'h020000);
    $display("vec -128 x -128: res24=%0h res16=%0h", res_data24, res_data16);
    handshake();

    // Valid skew: a_valid toggles, 2*3 x8 = 48
    for (int i = 0; i < 40 && !m_hold; i++) begin
      drive(bit'(i % 2), 8'd2, 1, 8'd3, 0, 0);
      step();
    end
    chk("lit_skew_valid", {63'd0, res_valid24}, 64'd1);
    chk("lit_skew48", {40'd0, res_data24}, 64'd48);
    $display("skew: res_data=%0d", $signed(res_data24));
    handshake();

    // clr after 3 accepts, then a clean vector of ones = 8
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'd7, 1, 8'd9, 0, 0);
      step();
    end
    drive(1, 8'd7, 1, 8'd9, 0, 1);
    step();
    chk("lit_clr_count", 64'(count24), 64'd0);
    chk("lit_clr_busy", {63'd0, busy24}, 64'd0);
    run_vec(1, 1, 0);
    chk("lit_after_clr8", {40'd0, res_data24}, 64'd8);
    $display("clr: after abort, ones vector res_data=%0d", $signed(res_data24));
    handshake();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), 8'($urandom),
            bit'($urandom_range(0, 3) != 0), 8'($urandom),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 39) == 0));
      step();
    end
    $display("random: 600 cycles done, checks so far=%0d", checks);

    // Asynchronous reset while holding a result
    drive(0, 8'd0, 0, 8'd0, 0, 1);
    step();
    run_vec(3, 4, 0);
    chk("lit_pre_rst96", {40'd0, res_data24}, 64'd96);
    rst = 1'b1;
    #1;
    model_reset();
    chk("lit_rst_valid", {63'd0, res_valid24}, 64'd0);
    chk("lit_rst_data24", {40'd0, res_data24}, 64'd0);
    chk("lit_rst_data16", {48'd0, res_data16}, 64'd0);
    check_all();
    step();
    rst = 1'b0;
    step();
    $display("async reset in HOLD: res_valid=%0d res_data=%0d", res_valid24, res_data24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_dot_mac.md
Name: fifo_dot_mac

Overview:
- Downstream consumer of the MMIO-fed FIFO stage in the AFU.
- Takes two streams of signed elements (A and B, each from a FIFO output) and computes their dot product over VEC_LEN element pairs.
- Presents the result on a valid/ready interface; the AFU returns it on a later MMIO read.
- Holds the result under backpressure and stalls input acceptance until the result is taken.

Parameters:
- DATA_W, 8, width of each signed input element.
- ACC_W, 24, width of the signed accumulator and result (ACC_W >= 2*DATA_W).
- VEC_LEN, 8, element pairs per dot product (>= 1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous abort/clear.
- a_valid  input  1  A element available.
- a_data  input  DATA_W  A element, signed.
- b_valid  input  1  B element available.
- b_data  input  DATA_W  B element, signed.
- in_ready  output  1  block can accept a pair (drives both FIFOs' pop/enable).
- res_valid  output  1  result available.
- res_data  output  ACC_W  dot-product result, signed.
- res_ready  input  1  consumer takes result.
- busy  output  1  high in ACCUM or HOLD.
- count  output  $clog2(VEC_LEN+1)  pairs accepted in the current vector.

Behaviour:
- Reset (asynchronous, rst high): state=IDLE; acc, count, res_data = 0; res_valid = 0; busy = 0. in_ready reads 1 once rst is released.
- accept = a_valid & b_valid & in_ready.
  - A lone a_valid or lone b_valid is not an accept; no state change.
  - in_ready is combinational from state only: 1 in IDLE/ACCUM, 0 in HOLD. It never depends on a_valid/b_valid.
- Product: signed DATA_W x DATA_W -> 2*DATA_W, sign-extended to ACC_W.
- Accumulate: acc + product, modulo 2^ACC_W (two's-complement wrap, no saturation, no overflow flag).
- States:
  - IDLE: on accept -> acc=product, count=1. Go to ACCUM, or to HOLD if VEC_LEN==1.
  - ACCUM: on accept -> acc+=product, count+=1. When that accept makes count==VEC_LEN: res_data<=acc+product, res_valid<=1, go to HOLD.
  - HOLD: res_valid=1; res_data stable; inputs ignored.
    - On res_valid & res_ready: res_valid<=0, acc<=0, count<=0, go to IDLE.
    - The first pair of the next vector is accepted no earlier than the cycle after the handshake.
- Latency: res_valid rises on the clock edge of the final accept, so it is visible the cycle after that accept.
- Throughput: one pair per cycle while both valids are high; VEC_LEN+1 cycles minimum per result with res_ready tied high.
- clr (synchronous, highest priority below rst):
  - Forces state=IDLE; acc, count = 0; res_valid = 0. res_data is unchanged.
  - Any accept or result handshake in the same cycle is discarded.
  - in_ready in the clr cycle follows the current state, so the FIFOs may pop a pair that is then dropped. This is required behaviour.
- rst asserted mid-vector or in HOLD: all state is lost immediately; no partial result is emitted.
- busy = (state != IDLE).
- count never exceeds VEC_LEN.

Decomposition:
- Package fifo_dot_mac_pkg holds:
  - default DATA_W, ACC_W, VEC_LEN constants;
  - state enum t_mac_state {IDLE, ACCUM, HOLD};
  - COUNT_W function ($clog2(VEC_LEN+1)).
- One sub-module, mac_pe: signed multiply + sign-extend + accumulate register, with inputs load/first/en. The FSM and handshake stay in fifo_dot_mac.

Test Plan:
- Defaults; a=1..8, b=1 each cycle, res_ready=1 -> res_valid one cycle after the 8th accept, res_data=36, count back to 0 after the handshake.
- Defaults; a=-128, b=127 for 8 pairs -> res_data=-130048 (24'hFE0400).
- ACC_W=16; a=-128, b=-128 for 8 pairs -> wraps to res_data=16'h0000.
- Backpressure: complete a vector, hold res_ready=0 for 5 cycles with a_valid=b_valid=1 -> in_ready=0, res_data stable, count=VEC_LEN, no FIFO pops. Raise res_ready -> IDLE next cycle, new vector starts.
- Valid skew: a_valid toggling, b_valid=1 -> only cycles with both high accept. a=2, b=3 over 8 accepts -> res_data=48.
- clr asserted after 3 accepts -> count=0, busy=0 next cycle. Then 8 pairs a=1, b=1 -> res_data=8. Separately, rst asserted in HOLD -> res_valid=0, res_data=0 immediately.
